// File: rtl/grn_node_lut_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : grn_node_lut_multi_if
//  Purpose  : Control, truth-table and status bundle of grn_node_lut_multi.
//  Revision : 1.0  initial release
// ============================================================================
interface grn_node_lut_multi_if #(
   parameter int NUM_IN     = 4,
   parameter int NUM_COPIES = 2,
   parameter int DIV_W      = 4
);
   logic                         reset_nos;
   logic                         init_state;
   logic [NUM_COPIES-1:0]        start;
   logic [NUM_COPIES*NUM_IN-1:0] in_bus;
   logic [NUM_COPIES*DIV_W-1:0]  div_cfg;
   logic                         lut_wr_en;
   logic [(2**NUM_IN)-1:0]       lut_wr_data;
   logic [NUM_COPIES-1:0]        state;
   logic [NUM_COPIES-1:0]        upd_valid;
   logic [NUM_COPIES-1:0]        stable;
   logic                         all_stable;

   modport master (
      output reset_nos, init_state, start, in_bus, div_cfg, lut_wr_en, lut_wr_data,
      input  state, upd_valid, stable, all_stable
   );

   modport slave (
      input  reset_nos, init_state, start, in_bus, div_cfg, lut_wr_en, lut_wr_data,
      output state, upd_valid, stable, all_stable
   );
endinterface
`default_nettype wire

// File: rtl/grn_node_lut_multi.sv
`default_nettype none
// ============================================================================
//  Module   : grn_node_lut_multi
//  Purpose  : GRN node with NUM_COPIES boolean states driven by one shared,
//             loadable truth table; per-copy update divider and stability flag.
//  Revision : 1.0  initial release
// ============================================================================
module grn_node_lut_multi #(
   parameter int NUM_IN     = 4,
   parameter int NUM_COPIES = 2,
   parameter int DIV_W      = 4,
   parameter int STAB_W     = 4,
   parameter int STABLE_TH  = 3
) (
   input  wire logic              clk,
   input  wire logic              rst,
   grn_node_lut_multi_if.slave    bus_if
);
   localparam int LUT_W = 2**NUM_IN;

   logic [LUT_W-1:0]      lut_q, lut_d;
   logic [NUM_COPIES-1:0] state_q, state_d;
   logic [NUM_COPIES-1:0] upd_q, upd_d;
   logic [NUM_COPIES-1:0] stable_q, stable_d;
   logic [DIV_W-1:0]      phase_q [NUM_COPIES];
   logic [DIV_W-1:0]      phase_d [NUM_COPIES];
   logic [STAB_W-1:0]     stab_q  [NUM_COPIES];
   logic [STAB_W-1:0]     stab_d  [NUM_COPIES];
   logic [NUM_COPIES-1:0] lut_sel;

   // Table lookup uses the registered table, so a same-cycle load sees old contents.
   generate
      for (genvar g = 0; g < NUM_COPIES; g++) begin : g_sel
         assign lut_sel[g] = lut_q[bus_if.in_bus[g*NUM_IN +: NUM_IN]];
      end
   endgenerate

   always_comb begin
      lut_d    = bus_if.lut_wr_en ? bus_if.lut_wr_data : lut_q;
      state_d  = state_q;
      upd_d    = '0;
      stable_d = stable_q;
      for (int k = 0; k < NUM_COPIES; k++) begin
         phase_d[k] = phase_q[k];
         stab_d[k]  = stab_q[k];
         if (bus_if.reset_nos) begin
            state_d[k] = bus_if.init_state;
            phase_d[k] = '0;
            stab_d[k]  = '0;
         end else if (bus_if.start[k]) begin
            if (phase_q[k] == '0) begin
               state_d[k] = lut_sel[k];
               upd_d[k]   = 1'b1;
               phase_d[k] = bus_if.div_cfg[k*DIV_W +: DIV_W];
               if (lut_sel[k] == state_q[k])
                  stab_d[k] = (stab_q[k] == {STAB_W{1'b1}}) ? stab_q[k] : stab_q[k] + STAB_W'(1);
               else
                  stab_d[k] = '0;
            end else begin
               phase_d[k] = phase_q[k] - DIV_W'(1);
            end
         end
         stable_d[k] = (stab_d[k] >= STAB_W'(STABLE_TH));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lut_q    <= '0;
         state_q  <= '0;
         upd_q    <= '0;
         stable_q <= '0;
         for (int k = 0; k < NUM_COPIES; k++) begin
            phase_q[k] <= '0;
            stab_q[k]  <= '0;
         end
      end else begin
         lut_q    <= lut_d;
         state_q  <= state_d;
         upd_q    <= upd_d;
         stable_q <= stable_d;
         for (int k = 0; k < NUM_COPIES; k++) begin
            phase_q[k] <= phase_d[k];
            stab_q[k]  <= stab_d[k];
         end
      end
   end

   assign bus_if.state      = state_q;
   assign bus_if.upd_valid  = upd_q;
   assign bus_if.stable     = stable_q;
   assign bus_if.all_stable = &stable_q;
endmodule
`default_nettype wire

// File: tb/tb_grn_node_lut_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grn_node_lut_multi
//  Purpose  : Scenario tasks plus randomized run against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_grn_node_lut_multi;
   localparam int NI = 4;
   localparam int NC = 2;
   localparam int DW = 4;
   localparam int TH = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   grn_node_lut_multi_if #(.NUM_IN(NI), .NUM_COPIES(NC), .DIV_W(DW)) bus_if ();

   grn_node_lut_multi #(
      .NUM_IN(NI), .NUM_COPIES(NC), .DIV_W(DW), .STAB_W(4), .STABLE_TH(TH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   always #5 clk = ~clk;

   // Model: skip counter = starts still to be ignored, run = consecutive unchanged updates.
   logic [15:0] m_lut;
   bit          m_state [NC];
   bit          m_upd   [NC];
   int          m_skip  [NC];
   int          m_run   [NC];

   task automatic model_clear();
      m_lut = '0;
      for (int k = 0; k < NC; k++) begin
         m_state[k] = 0; m_upd[k] = 0; m_skip[k] = 0; m_run[k] = 0;
      end
   endtask

   function automatic logic [NC-1:0] exp_state();
      for (int k = 0; k < NC; k++) exp_state[k] = m_state[k];
   endfunction
   function automatic logic [NC-1:0] exp_upd();
      for (int k = 0; k < NC; k++) exp_upd[k] = m_upd[k];
   endfunction
   function automatic logic [NC-1:0] exp_stable();
      for (int k = 0; k < NC; k++) exp_stable[k] = (m_run[k] >= TH);
   endfunction

   task automatic cycle();
      logic [NI-1:0] idx;
      bit nv;
      for (int k = 0; k < NC; k++) begin
         if (bus_if.reset_nos) begin
            m_state[k] = bus_if.init_state; m_skip[k] = 0; m_run[k] = 0; m_upd[k] = 0;
         end else if (bus_if.start[k]) begin
            if (m_skip[k] == 0) begin
               idx = bus_if.in_bus[k*NI +: NI];
               nv  = m_lut[idx];
               m_run[k]   = (nv == m_state[k]) ? m_run[k] + 1 : 0;
               m_state[k] = nv;
               m_upd[k]   = 1;
               m_skip[k]  = int'(bus_if.div_cfg[k*DW +: DW]);
            end else begin
               m_skip[k]--; m_upd[k] = 0;
            end
         end else begin
            m_upd[k] = 0;
         end
      end
      if (bus_if.lut_wr_en) m_lut = bus_if.lut_wr_data;
      @(posedge clk);
      #1;
      bus_if.start = '0; bus_if.reset_nos = 0; bus_if.lut_wr_en = 0;
   endtask

   task automatic load_lut(input logic [15:0] t);
      bus_if.lut_wr_en = 1; bus_if.lut_wr_data = t;
      cycle();
   endtask

   task automatic renos(input bit init);
      bus_if.reset_nos = 1; bus_if.init_state = init;
      cycle();
   endtask

   task automatic test_reset();
      n_cmp++;
      if (bus_if.state !== 2'b00 || bus_if.upd_valid !== 2'b00 || bus_if.stable !== 2'b00
          || bus_if.all_stable !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: state=%b upd=%b stable=%b all=%b required all zero",
                  bus_if.state, bus_if.upd_valid, bus_if.stable, bus_if.all_stable);
      end
   endtask

   task automatic test_async_rst();
      load_lut(16'hFFFF);
      bus_if.div_cfg = '0;
      for (int i = 0; i < 4; i++) begin
         bus_if.start = 2'b11; bus_if.in_bus = 8'($urandom);
         cycle();
      end
      n_cmp++;
      if (bus_if.state !== 2'b11 || bus_if.stable !== 2'b11) begin
         n_fail++;
         $display("FAIL pre_rst: state=%b stable=%b required 11/11", bus_if.state, bus_if.stable);
      end
      #3 rst = 1;
      #1;
      n_cmp++;
      if (bus_if.state !== 2'b00 || bus_if.upd_valid !== 2'b00 || bus_if.stable !== 2'b00
          || bus_if.all_stable !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst: state=%b upd=%b stable=%b all=%b required all zero",
                  bus_if.state, bus_if.upd_valid, bus_if.stable, bus_if.all_stable);
      end
      #2 rst = 0;
      model_clear();
      @(posedge clk); #1;
      bus_if.start = 2'b11; bus_if.in_bus = 8'($urandom);
      cycle();
      n_cmp++;
      if (bus_if.state !== 2'b00 || bus_if.upd_valid !== 2'b11) begin
         n_fail++;
         $display("FAIL lut_cleared: state=%b upd=%b required 00/11", bus_if.state, bus_if.upd_valid);
      end
   endtask

   task automatic test_or_lut();
      load_lut(16'hFFFE);
      bus_if.div_cfg = '0;
      renos(0);
      bus_if.start = 2'b01; bus_if.in_bus = 8'h00;
      cycle();
      n_cmp++;
      if (bus_if.state[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL or_zero: state0=%b required 0", bus_if.state[0]);
      end
      bus_if.start = 2'b01; bus_if.in_bus = 8'h04;
      cycle();
      n_cmp++;
      if (bus_if.state[0] !== 1'b1 || bus_if.upd_valid[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL or_one: state0=%b upd0=%b required 1/1", bus_if.state[0], bus_if.upd_valid[0]);
      end
   endtask

   task automatic test_divider();
      logic [5:0] pat;
      pat = 6'b010101;
      bus_if.div_cfg = 8'h01;
      load_lut(16'($urandom));
      renos(1'($urandom));
      for (int i = 0; i < 6; i++) begin
         bus_if.start = 2'b01; bus_if.in_bus = 8'($urandom);
         cycle();
         n_cmp++;
         if (bus_if.upd_valid[0] !== pat[i] || bus_if.state !== exp_state()) begin
            n_fail++;
            $display("FAIL divider[%0d]: upd0=%b state=%b required %b/%b", i,
                     bus_if.upd_valid[0], bus_if.state, pat[i], exp_state());
         end
      end
   endtask

   task automatic test_stability();
      logic [2:0] pat;
      pat = 3'b100;
      bus_if.div_cfg = '0;
      load_lut(16'hFFFE);
      renos(1);
      for (int i = 0; i < 3; i++) begin
         bus_if.start = 2'b01; bus_if.in_bus = 8'h04;
         cycle();
         n_cmp++;
         if (bus_if.stable[0] !== pat[i]) begin
            n_fail++;
            $display("FAIL stab_rise[%0d]: stable0=%b required %b", i, bus_if.stable[0], pat[i]);
         end
      end
      bus_if.start = 2'b01; bus_if.in_bus = 8'h00;
      cycle();
      n_cmp++;
      if (bus_if.stable[0] !== 1'b0 || bus_if.state[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL stab_fall: stable0=%b state0=%b required 0/0", bus_if.stable[0], bus_if.state[0]);
      end
   endtask

   task automatic test_lut_same_cycle();
      bus_if.div_cfg = '0;
      bus_if.start = 2'b01; bus_if.in_bus = 8'h00;
      bus_if.lut_wr_en = 1; bus_if.lut_wr_data = 16'h0001;
      cycle();
      n_cmp++;
      if (bus_if.state[0] !== 1'b0 || bus_if.upd_valid[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL lut_old: state0=%b upd0=%b required 0/1", bus_if.state[0], bus_if.upd_valid[0]);
      end
      bus_if.start = 2'b01; bus_if.in_bus = 8'h00;
      cycle();
      n_cmp++;
      if (bus_if.state[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL lut_new: state0=%b required 1", bus_if.state[0]);
      end
   endtask

   task automatic test_renos_start();
      bus_if.div_cfg = 8'h33;
      bus_if.start = 2'b11; bus_if.in_bus = 8'h00;
      cycle();
      bus_if.start = 2'b11; bus_if.reset_nos = 1; bus_if.init_state = 1;
      cycle();
      n_cmp++;
      if (bus_if.state !== 2'b11 || bus_if.upd_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL renos_start: state=%b upd=%b required 11/00", bus_if.state, bus_if.upd_valid);
      end
      bus_if.start = 2'b11; bus_if.in_bus = 8'($urandom);
      cycle();
      n_cmp++;
      if (bus_if.upd_valid !== 2'b11 || bus_if.state !== exp_state()) begin
         n_fail++;
         $display("FAIL renos_next: upd=%b state=%b required 11/%b", bus_if.upd_valid,
                  bus_if.state, exp_state());
      end
   endtask

   task automatic test_random();
      logic [NC-1:0] es, eu, eb;
      for (int i = 0; i < 400; i++) begin
         bus_if.start     = 2'($urandom);
         bus_if.in_bus    = 8'($urandom_range(0, 3) == 0 ? $urandom : 32'h0000_0044);
         bus_if.reset_nos = ($urandom_range(0, 39) == 0);
         bus_if.init_state = 1'($urandom);
         bus_if.lut_wr_en = ($urandom_range(0, 29) == 0);
         bus_if.lut_wr_data = 16'($urandom);
         if ($urandom_range(0, 19) == 0) bus_if.div_cfg = 8'($urandom & 32'h33);
         cycle();
         es = exp_state(); eu = exp_upd(); eb = exp_stable();
         n_cmp++;
         if (bus_if.state !== es || bus_if.upd_valid !== eu || bus_if.stable !== eb
             || bus_if.all_stable !== (&eb)) begin
            n_fail++;
            $display("FAIL random[%0d]: state=%b upd=%b stable=%b all=%b required %b/%b/%b/%b",
                     i, bus_if.state, bus_if.upd_valid, bus_if.stable, bus_if.all_stable,
                     es, eu, eb, &eb);
         end
      end
   endtask

   initial begin
      bus_if.reset_nos = 0; bus_if.init_state = 0; bus_if.start = '0; bus_if.in_bus = '0;
      bus_if.div_cfg = '0; bus_if.lut_wr_en = 0; bus_if.lut_wr_data = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 0;
      test_async_rst();
      test_or_lut();
      test_divider();
      test_stability();
      test_lut_same_cycle();
      test_renos_start();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
